// File: rtl/lookup_arbiter.sv
// lookup_arbiter: round-robin sharing of the single routing-table port among
// PORTS input channels. A winner's destination is driven on table_addr, and the
// table result is registered and returned over a 4-phase req/ack handshake.
module lookup_arbiter #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8,
    parameter int DEST_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORTS-1:0]           req,
    input  logic [PORTS*DEST_BITS-1:0] dest,
    output logic [PORTS-1:0]           ack,
    output logic [PORT_BITS-1:0]       result,
    output logic                       busy,
    output logic [DEST_BITS-1:0]       table_addr,
    input  logic [PORT_BITS-1:0]       table_data
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DEST_BITS-1:0] addr_d;
    logic [PORTS-1:0]     ack_d;
    logic [PORT_BITS-1:0] result_d;

    logic [DEST_BITS-1:0] dest_arr [PORTS];
    logic [IDX_W:0]       cand;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    // Unpack the flat destination bus so inputs can be indexed directly.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            dest_arr[i] = dest[i*DEST_BITS +: DEST_BITS];
        end
    end

    // Round-robin search: first requester after rr_ptr, wrapping modulo PORTS.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(PORTS)) begin
                cand = cand - (IDX_W+1)'(PORTS);
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; registers hold unless a state acts.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = table_addr;
        ack_d    = ack;
        result_d = result;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                    addr_d   = dest_arr[pick_idx];
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                // A requester that withdrew during the lookup gets no ack.
                if (req[grant_q]) begin
                    result_d        = table_data;
                    ack_d           = '0;
                    ack_d[grant_q]  = 1'b1;
                    state_d         = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!req[grant_q]) begin
                    ack_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset makes input 0 the first winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= IDX_W'(PORTS - 1);
            table_addr <= '0;
            ack        <= '0;
            result     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            table_addr <= addr_d;
            ack        <= ack_d;
            result     <= result_d;
        end
    end

    // busy is decoded straight from the state register.
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_lookup_arbiter.sv
// tb_lookup_arbiter: directed scenarios plus randomized request sets, checked
// against a transaction-level round-robin model and a fixed routing table.
module tb_lookup_arbiter;

    localparam int PORTS     = 5;
    localparam int PORT_BITS = 8;
    localparam int DEST_BITS = 7;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [PORTS-1:0]           req;
    logic [PORTS*DEST_BITS-1:0] dest;
    logic [PORTS-1:0]           ack;
    logic [PORT_BITS-1:0]       result;
    logic                       busy;
    logic [DEST_BITS-1:0]       table_addr;
    logic [PORT_BITS-1:0]       table_data;

    int n_pass  = 0;
    int n_total = 0;
    int last_win;

    lookup_arbiter #(
        .PORTS(PORTS), .PORT_BITS(PORT_BITS), .DEST_BITS(DEST_BITS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .dest(dest), .ack(ack),
        .result(result), .busy(busy), .table_addr(table_addr),
        .table_data(table_data)
    );

    always #5 clk = ~clk;

    // Routing table: 0->0, 1->2, 2->1, 3->2, everything else -> 4.
    function automatic logic [PORT_BITS-1:0] table_fn(input logic [DEST_BITS-1:0] a);
        case (a)
            7'd0:    return 8'd0;
            7'd1:    return 8'd2;
            7'd2:    return 8'd1;
            7'd3:    return 8'd2;
            default: return 8'd4;
        endcase
    endfunction

    always_comb table_data = table_fn(table_addr);

    // Model: winner is the first pending index after the previous winner.
    function automatic int rr_next(input int last, input logic [PORTS-1:0] mask);
        for (int k = 1; k <= PORTS; k++) begin
            if (mask[(last + k) % PORTS]) return (last + k) % PORTS;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int i, input int d);
        dest[i*DEST_BITS +: DEST_BITS] = DEST_BITS'(d);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        last_win = PORTS - 1;
    endtask

    // Serve every pending request (already raised); the first n_regrants
    // winners re-raise req right after their ack falls.
    task automatic serve(input logic [PORTS-1:0] mask, input int n_regrants, input string tag);
        logic [PORTS-1:0]     pending;
        logic [PORTS-1:0]     exp_ack;
        logic [PORT_BITS-1:0] exp_res;
        int win, lat, g, h;
        pending = mask;
        g = 0;
        while (pending != '0) begin
            win     = rr_next(last_win, pending);
            exp_ack = PORTS'(1) << win;
            exp_res = table_fn(dest[win*DEST_BITS +: DEST_BITS]);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (ack == '0 && lat < 12);
            n_total++;
            if (lat !== 2) $display("FAIL %s_latency: got %0d edges, want 2", tag, lat);
            else n_pass++;
            n_total++;
            if (ack !== exp_ack) $display("FAIL %s_grant: ack=%b, want %b", tag, ack, exp_ack);
            else n_pass++;
            n_total++;
            if (result !== exp_res) $display("FAIL %s_result: got %0d, want %0d", tag, result, exp_res);
            else n_pass++;
            if (ack == '0) begin
                req = '0;
                repeat (3) tick();
                apply_reset();
                break;
            end
            h = $urandom_range(0, 2);
            repeat (h) begin
                tick();
                n_total++;
                if (ack !== exp_ack || result !== exp_res)
                    $display("FAIL %s_hold: ack=%b result=%0d, want %b/%0d", tag, ack, result, exp_ack, exp_res);
                else n_pass++;
            end
            req[win]     = 1'b0;
            pending[win] = 1'b0;
            last_win     = win;
            tick();
            n_total++;
            if (ack !== '0 || busy !== 1'b0)
                $display("FAIL %s_release: ack=%b busy=%b, want 0/0", tag, ack, busy);
            else n_pass++;
            if (g < n_regrants) begin
                req[win]     = 1'b1;
                pending[win] = 1'b1;
            end
            g++;
        end
    endtask

    task automatic test_reset();
        n_total++;
        if (ack !== '0 || busy !== 1'b0 || result !== '0 || table_addr !== '0)
            $display("FAIL reset_values: ack=%b busy=%b result=%0d addr=%0d, want all 0",
                     ack, busy, result, table_addr);
        else n_pass++;
    endtask

    task automatic test_single();
        set_dest(2, 1);
        req[2] = 1'b1;
        tick();
        n_total++;
        if (table_addr !== 7'd1 || busy !== 1'b1 || ack !== '0)
            $display("FAIL single_grant: addr=%0d busy=%b ack=%b, want 1/1/0", table_addr, busy, ack);
        else n_pass++;
        tick();
        n_total++;
        if (ack !== 5'b00100 || result !== 8'd2)
            $display("FAIL single_ack: ack=%b result=%0d, want 00100/2", ack, result);
        else n_pass++;
        req[2] = 1'b0;
        tick();
        n_total++;
        if (ack !== '0 || busy !== 1'b0)
            $display("FAIL single_release: ack=%b busy=%b, want 0/0", ack, busy);
        else n_pass++;
        last_win = 2;
    endtask

    task automatic test_all_five();
        apply_reset();
        for (int i = 0; i < PORTS; i++) set_dest(i, i);
        req = '1;
        serve('1, 0, "all_five");
        req[0] = 1'b1;
        serve(5'b00001, 0, "wrap");
    endtask

    task automatic test_long_hold();
        set_dest(1, 9);
        req[1] = 1'b1;
        tick();
        tick();
        n_total++;
        if (ack !== 5'b00010 || result !== 8'd4)
            $display("FAIL hold_ack: ack=%b result=%0d, want 00010/4", ack, result);
        else n_pass++;
        repeat (5) begin
            tick();
            n_total++;
            if (ack !== 5'b00010 || result !== 8'd4 || busy !== 1'b1)
                $display("FAIL hold_stable: ack=%b result=%0d busy=%b, want 00010/4/1", ack, result, busy);
            else n_pass++;
        end
        req[1] = 1'b0;
        tick();
        n_total++;
        if (ack !== '0) $display("FAIL hold_release: ack=%b, want 0", ack);
        else n_pass++;
        last_win = 1;
    endtask

    task automatic test_withdraw();
        set_dest(3, 3);
        req[3] = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b1 || table_addr !== 7'd3)
            $display("FAIL withdraw_grant: busy=%b addr=%0d, want 1/3", busy, table_addr);
        else n_pass++;
        req[3] = 1'b0;
        tick();
        n_total++;
        if (ack !== '0 || busy !== 1'b0)
            $display("FAIL withdraw_abort: ack=%b busy=%b, want 0/0", ack, busy);
        else n_pass++;
        last_win = 3;
        tick();
        n_total++;
        if (ack !== '0) $display("FAIL withdraw_no_ack: ack=%b, want 0", ack);
        else n_pass++;
        req[3] = 1'b1;
        serve(5'b01000, 0, "withdraw_retry");
    endtask

    task automatic test_alternate();
        set_dest(0, 2);
        set_dest(3, 1);
        req = 5'b01001;
        serve(5'b01001, 4, "alternate");
    endtask

    task automatic test_reset_mid_hold();
        set_dest(4, 4);
        req[4] = 1'b1;
        tick();
        tick();
        n_total++;
        if (ack !== 5'b10000) $display("FAIL midrst_ack: ack=%b, want 10000", ack);
        else n_pass++;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (ack !== '0 || busy !== 1'b0 || table_addr !== '0 || result !== '0)
            $display("FAIL midrst_clear: ack=%b busy=%b addr=%0d result=%0d, want all 0",
                     ack, busy, table_addr, result);
        else n_pass++;
        req = '0;
        #1;
        reset = 1'b0;
        last_win = PORTS - 1;
        set_dest(1, 3);
        set_dest(4, 0);
        req = 5'b10010;
        serve(5'b10010, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [PORTS-1:0] mask;
        repeat (25) begin
            mask = PORTS'($urandom_range(1, (1 << PORTS) - 1));
            for (int i = 0; i < PORTS; i++) set_dest(i, $urandom_range(0, (1 << DEST_BITS) - 1));
            req = mask;
            serve(mask, 0, "random");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        dest     = '0;
        last_win = PORTS - 1;
        #12;
        test_reset();
        reset = 1'b0;
        tick();
        test_single();
        test_all_five();
        test_long_hold();
        test_withdraw();
        test_alternate();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
